// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte handshake bundle between uart_rx and its consumer
interface uart_rx_if #(
  parameter int C_DATA_BITS = 8
);
  logic [C_DATA_BITS-1:0] rx_data;
  logic                   rx_valid;
  logic                   rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with one-entry holding register
// Optional even-parity bit and parity_err_o port enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int C_DATA_BITS  = 8,
  parameter int C_OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      baud_tick_i,
  input  logic      rx_i,
  uart_rx_if.master rx_bus,
  output logic      frame_err_o,
`ifdef UART_RX_PARITY_EN
  output logic      parity_err_o,
`endif
  output logic      overrun_err_o
);

  localparam int TW = $clog2(C_OVERSAMPLE);
  localparam int BW = (C_DATA_BITS > 1) ? $clog2(C_DATA_BITS) : 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(C_OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(C_OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(C_DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rx_sync_q;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [C_DATA_BITS-1:0] shift_q, shift_d;
  logic                   armed_q, armed_d;
  logic [C_DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_err_q, overrun_err_d;
  logic                   byte_done;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   parity_err_q, parity_err_d;
`endif

  // armed_q records that the line was seen high since the last start, so only a fresh falling edge starts a frame
  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    armed_d       = armed_q;
    byte_done     = 1'b0;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d     = par_bad_q;
    parity_err_d  = 1'b0;
`endif
    if (baud_tick_i) begin
      case (state_q)
        S_IDLE: begin
          if (rx_sync_q) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            armed_d    = 1'b0;
            tick_cnt_d = '0;
            state_d    = S_START;
          end
        end
        S_START: begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rx_sync_q, shift_q[C_DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            par_bad_d  = rx_sync_q ^ (^shift_q);
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            state_d    = S_IDLE;
            if (!rx_sync_q) begin
              frame_err_d = 1'b1;
              armed_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_q) begin
              parity_err_d = 1'b1;
`endif
            end else begin
              byte_done = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (byte_done) begin
      if (!rx_valid_q || rx_bus.rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end else if (rx_valid_q && rx_bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      armed_q       <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rx_meta_q     <= rx_i;
      rx_sync_q     <= rx_meta_q;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      armed_q       <= armed_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= par_bad_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign rx_bus.rx_data  = rx_data_q;
  assign rx_bus.rx_valid = rx_valid_q;
  assign frame_err_o     = frame_err_q;
  assign overrun_err_o   = overrun_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o    = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx (directed frames, errors, reset)
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic baud_tick = 1'b0;
  logic rx = 1'b1;
  logic frame_err, overrun_err;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  logic par_flip = 1'b0;
`endif
  int checks = 0;
  int errors = 0;
  int div_cnt = 0;
  logic tick_prev = 1'b0;
  logic valid_prev = 1'b0;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  localparam int K_DATA = 0;
  localparam int K_FERR = 1;
  localparam int K_OVR  = 2;
  localparam int K_PERR = 3;

  uart_rx_if #(.C_DATA_BITS(8)) bus ();

  uart_rx #(.C_DATA_BITS(8), .C_OVERSAMPLE(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .baud_tick_i  (baud_tick),
    .rx_i         (rx),
    .rx_bus       (bus),
    .frame_err_o  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err_o (parity_err),
`endif
    .overrun_err_o(overrun_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      div_cnt   = (div_cnt + 1) % 4;
      baud_tick = (div_cnt == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pop_expect(input int kind, input logic [7:0] data, input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s actual=%0h required=none", name, data);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, kind, e.kind);
      if (kind == K_DATA) check(name, data, e.data);
    end
  endtask

  task automatic push_exp(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_err) pop_expect(K_FERR, 8'h00, "frame_err");
        if (overrun_err) pop_expect(K_OVR, 8'h00, "overrun_err");
`ifdef UART_RX_PARITY_EN
        if (parity_err) pop_expect(K_PERR, 8'h00, "parity_err");
`endif
        if (bus.rx_valid && !valid_prev) check("valid_latency_tick", {31'b0, tick_prev}, 32'd1);
        if (bus.rx_valid && bus.rx_ready) pop_expect(K_DATA, bus.rx_data, "rx_data");
      end
      tick_prev  = baud_tick;
      valid_prev = bus.rx_valid;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    step(64);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_b, input int abort_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        rx = data[i];
        step(32);
        return;
      end
      send_bit(data[i]);
    end
`ifdef UART_RX_PARITY_EN
    send_bit((^data) ^ par_flip);
`endif
    send_bit(stop_b);
    rx = 1'b1;
    step(40);
  endtask

  task automatic check_outputs_cleared(input string tag);
    check({tag, "_rx_valid"}, {31'b0, bus.rx_valid}, 32'd0);
    check({tag, "_rx_data"}, {24'b0, bus.rx_data}, 32'd0);
    check({tag, "_frame_err"}, {31'b0, frame_err}, 32'd0);
    check({tag, "_overrun_err"}, {31'b0, overrun_err}, 32'd0);
  endtask

  initial begin
    bus.rx_ready = 1'b1;
    #1 rst = 1'b1;
    #1 check_outputs_cleared("reset");
    step(3);
    rst = 1'b0;
    step(40);

    push_exp(K_DATA, 8'hA5);
    send_frame(8'hA5, 1'b1, -1);

    rx = 1'b0;
    step(16);
    rx = 1'b1;
    step(100);
    check("glitch_rx_valid", {31'b0, bus.rx_valid}, 32'd0);

    push_exp(K_FERR, 8'h00);
    send_frame(8'h3C, 1'b0, -1);
    push_exp(K_DATA, 8'h55);
    send_frame(8'h55, 1'b1, -1);

    bus.rx_ready = 1'b0;
    push_exp(K_OVR, 8'h00);
    push_exp(K_DATA, 8'h11);
    send_frame(8'h11, 1'b1, -1);
    check("hold_valid", {31'b0, bus.rx_valid}, 32'd1);
    send_frame(8'h22, 1'b1, -1);
    check("hold_data", {24'b0, bus.rx_data}, 32'h11);
    bus.rx_ready = 1'b1;
    step(2);
    check("valid_cleared", {31'b0, bus.rx_valid}, 32'd0);

    send_frame(8'hFF, 1'b1, 3);
    rst = 1'b1;
    #1 check_outputs_cleared("midframe_reset");
    step(3);
    rx  = 1'b1;
    rst = 1'b0;
    step(40);
    push_exp(K_DATA, 8'h81);
    send_frame(8'h81, 1'b1, -1);

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    push_exp(K_PERR, 8'h00);
    send_frame(8'h07, 1'b1, -1);
    par_flip = 1'b0;
    push_exp(K_DATA, 8'h07);
    send_frame(8'h07, 1'b1, -1);
`endif

    step(20);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 C_DATA_BITS, 8, number of data bits per frame (5..9), LSB first on the line.
REQ-002 C_OVERSAMPLE, 16, baud_tick pulses per bit period (even, >=4).
REQ-003 Clk  input  1  single system clock; all logic on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 baud_tick  input  1  one-Clk-wide strobe at C_OVERSAMPLE x baud rate, from the baud tick generator.
REQ-006 rx  input  1  asynchronous serial line; idle high.
REQ-007 rx_data  output  C_DATA_BITS  last received byte; stable while rx_valid=1.
REQ-008 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready in the same cycle.
REQ-010 frame_err  output  1  one-Clk pulse: stop bit sampled low.
REQ-011 overrun_err  output  1  one-Clk pulse: byte completed while the holding register was full and not being consumed.

Function
REQ-012 rx SHALL pass through a two-flop synchronizer; only the synchronized value is used.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; tick counter and bit counter advance only on baud_tick=1.
REQ-014 IDLE: a high-to-low transition of synchronized rx SHALL enter START with the tick counter cleared.
REQ-015 START: after C_OVERSAMPLE/2 ticks, rx=0 enters DATA (counters cleared); rx=1 is a glitch and returns to IDLE with no error.
REQ-016 DATA: every C_OVERSAMPLE ticks one bit SHALL be sampled and shifted in LSB first; after C_DATA_BITS bits enter STOP.
REQ-017 STOP: after C_OVERSAMPLE ticks rx is sampled; rx=1 completes the byte, rx=0 pulses frame_err, discards the byte; both return to IDLE.
REQ-018 IDLE after a frame error SHALL wait for rx high then a new falling edge before starting.
REQ-019 Completed byte with rx_valid=0, or with rx_valid=1 & rx_ready=1 in that cycle: load rx_data, rx_valid=1 next cycle.
REQ-020 Completed byte with rx_valid=1 & rx_ready=0: pulse overrun_err, keep old rx_data, drop new byte.
REQ-021 rx_valid & rx_ready with no completion SHALL clear rx_valid next cycle.
REQ-022 Completion to rx_valid latency SHALL be exactly one Clk after the stop-bit sample tick.
REQ-023 baud_tick held low SHALL freeze the FSM in its current state.

Reset
REQ-024 Reset=1 SHALL immediately force IDLE, counters 0, synchronizer flops 1, rx_data 0, rx_valid 0, frame_err 0, overrun_err 0.
REQ-025 Reset mid-frame SHALL abandon the frame without error pulses; reception resumes on the next falling edge after release.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: an even-parity bit follows the data bits (state PARITY between DATA and STOP), and an extra output parity_err (1-bit, one-Clk pulse, reset 0) flags mismatch; byte with parity error is discarded.
REQ-027 Macro undefined: no PARITY state, no parity_err port, frame = start + C_DATA_BITS + stop.

Verification
REQ-028 Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at C_OVERSAMPLE=16, rx_ready=1 -> rx_data=0xA5, rx_valid one cycle after stop sample, no error pulses.
REQ-029 rx low for 4 ticks then high in IDLE -> return to IDLE, rx_valid stays 0, no frame_err.
REQ-030 Frame 0x3C with stop bit 0 -> frame_err one pulse, rx_valid stays 0; next frame 0x55 received correctly.
REQ-031 rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 held, overrun_err one pulse at second completion; rx_ready=1 clears rx_valid.
REQ-032 Reset asserted during DATA bit 3 of 0xFF -> all outputs 0 immediately; after release, frame 0x81 received as 0x81.
REQ-033 UART_RX_PARITY_EN defined, 0x07 with parity bit 0 (wrong) -> parity_err one pulse, no rx_valid; with parity 1 -> rx_data=0x07.
